// File: rtl/stream_block_avg_pkg.sv
// Shared constants for the block averager: default widths, accumulator
// width, log2_n port width and the control state encoding.
package stream_block_avg_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned MAX_LOG2_DEF = 10;
  localparam int unsigned LOG2_W       = 4;

  // Sum of 2^MAX_LOG2 full-scale samples fits with MAX_LOG2 guard bits.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned max_log2);
    return data_w + max_log2;
  endfunction

  localparam int unsigned ACC_W_DEF = acc_width(DATA_W_DEF, MAX_LOG2_DEF);

  localparam int unsigned STATE_W  = 1;
  localparam logic [0:0]  ST_IDLE  = 1'b0;
  localparam logic [0:0]  ST_ACCUM = 1'b1;

endpackage

// File: rtl/stream_block_avg_ctrl.sv
// Block averager control: IDLE/ACCUM state machine, per-block sample
// counter, latched block exponent k and sticky overrun flag.
// Ports:
//   clk, rst_n       clock, async active-low reset (already synchronised)
//   enable           averaging active; low flushes to IDLE
//   log2_n           requested block exponent (clamped to MAX_LOG2)
//   data_in_valid    input sample strobe
//   k                exponent of the block in progress
//   sample_cnt       samples accepted in the current block
//   overrun          sticky: log2_n changed while a block was partial
//   accept_c         sample is accepted this cycle
//   last_c           accepted sample completes the block
module block_avg_ctrl
  import stream_block_avg_pkg::*;
#(
  parameter int unsigned MAX_LOG2 = MAX_LOG2_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [LOG2_W-1:0]   log2_n,
  input  logic                data_in_valid,
  output logic [LOG2_W-1:0]   k,
  output logic [MAX_LOG2:0]   sample_cnt,
  output logic                overrun,
  output logic                accept_c,
  output logic                last_c
);

  localparam int unsigned CNT_W = MAX_LOG2 + 1;

  logic [STATE_W-1:0] state_q, state_d;
  logic [LOG2_W-1:0]  k_q, k_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovr_q, ovr_d;

  logic [LOG2_W-1:0]  k_req_c;
  logic [CNT_W-1:0]   block_len_c;

  // Requested exponent clamped to the supported range.
  assign k_req_c     = (log2_n > LOG2_W'(MAX_LOG2)) ? LOG2_W'(MAX_LOG2) : log2_n;
  assign block_len_c = CNT_W'(1) << k_q;

  assign accept_c = (state_q == ST_ACCUM) && enable && data_in_valid;
  assign last_c   = accept_c && ((cnt_q + CNT_W'(1)) == block_len_c);

  // State and control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        ovr_d = 1'b0;
        if (enable) begin
          state_d = ST_ACCUM;
          k_d     = k_req_c;
        end
      end
      ST_ACCUM: begin
        if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          ovr_d   = 1'b0;
        end else begin
          // Old k keeps governing the partial block; only flag the change.
          if ((cnt_q != '0) && (k_req_c != k_q)) begin
            ovr_d = 1'b1;
          end
          if (last_c) begin
            cnt_d = '0;
            k_d   = k_req_c;
          end else if (accept_c) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign k          = k_q;
  assign sample_cnt = cnt_q;
  assign overrun    = ovr_q;

endmodule

// File: rtl/stream_block_avg.sv
// Streaming block averager: sums 2^k consecutive valid samples and emits
// their truncated mean one clock after the block-completing sample.
// Ports:
//   clk, reset_n      clock, async active-low reset (release synchronised)
//   enable            averaging active; low flushes partial block
//   log2_n            requested block length exponent
//   data_in_valid     input sample strobe
//   data_in           unsigned input sample
//   data_out          block average, holds between strobes
//   data_out_valid    one-cycle strobe qualifying data_out
//   sample_cnt        samples accumulated in the current block
//   overrun           sticky flag: log2_n changed mid-block
module stream_block_avg
  import stream_block_avg_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_LOG2 = MAX_LOG2_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [LOG2_W-1:0] log2_n,
  input  logic              data_in_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic [MAX_LOG2:0] sample_cnt,
  output logic              overrun
);

  localparam int unsigned ACC_W = acc_width(DATA_W, MAX_LOG2);

  logic [1:0]        rst_sync_q;
  logic              rst_n;
  logic [LOG2_W-1:0] k;
  logic              accept_c;
  logic              last_c;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  sum_c;

  // Reset asserts immediately, releases two clock edges later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  block_avg_ctrl #(
    .MAX_LOG2 (MAX_LOG2)
  ) u_ctrl (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .log2_n        (log2_n),
    .data_in_valid (data_in_valid),
    .k             (k),
    .sample_cnt    (sample_cnt),
    .overrun       (overrun),
    .accept_c      (accept_c),
    .last_c        (last_c)
  );

  // Sum including the current sample, so the final sample joins its block.
  assign sum_c = acc_q + ACC_W'(data_in);

  // Accumulator, shifter and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q          <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      data_out_valid <= 1'b0;
      if (!enable) begin
        acc_q <= '0;
      end else if (last_c) begin
        acc_q          <= '0;
        data_out       <= DATA_W'(sum_c >> k);
        data_out_valid <= 1'b1;
      end else if (accept_c) begin
        acc_q <= sum_c;
      end
    end
  end

endmodule

// File: tb/tb_stream_block_avg.sv
// Self-checking bench for stream_block_avg: a cycle model of the averaging
// rules is compared against the DUT every cycle, plus directed literal checks.
module tb_stream_block_avg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MAX_LOG2 = 10;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic [3:0]        log2_n = 4'd0;
  logic              data_in_valid = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0] data_out;
  logic              data_out_valid;
  logic [MAX_LOG2:0] sample_cnt;
  logic              overrun;

  int checks = 0;
  int failures = 0;
  int strobes = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  stream_block_avg #(
    .DATA_W   (DATA_W),
    .MAX_LOG2 (MAX_LOG2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .log2_n         (log2_n),
    .data_in_valid  (data_in_valid),
    .data_in        (data_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .sample_cnt     (sample_cnt),
    .overrun        (overrun)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int l);
    return (l > int'(MAX_LOG2)) ? int'(MAX_LOG2) : l;
  endfunction

  // Behavioural model: blocks of 2^k samples, mean by truncating shift.
  int     m_rel = 0;
  bit     m_active = 1'b0;
  int     m_k = 0;
  longint m_sum = 0;
  int     m_cnt = 0;
  bit     m_ovr = 1'b0;
  bit     m_valid = 1'b0;
  longint m_data = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_rel = 0; m_active = 0; m_k = 0; m_sum = 0;
      m_cnt = 0; m_ovr = 0; m_valid = 0; m_data = 0;
    end else if (m_rel < 2) begin
      m_rel++;
      m_valid = 0;
    end else begin
      m_valid = 0;
      if (!enable) begin
        m_active = 0; m_sum = 0; m_cnt = 0; m_ovr = 0;
      end else if (!m_active) begin
        m_active = 1; m_k = clamp(int'(log2_n)); m_sum = 0; m_cnt = 0;
      end else begin
        if (m_cnt > 0 && clamp(int'(log2_n)) != m_k) m_ovr = 1;
        if (data_in_valid) begin
          m_sum = m_sum + longint'(data_in);
          m_cnt++;
          if (m_cnt == (1 << m_k)) begin
            m_data  = (m_sum >> m_k) & 64'hFFFF_FFFF;
            m_valid = 1;
            m_sum   = 0;
            m_cnt   = 0;
            m_k     = clamp(int'(log2_n));
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_valid", 64'(data_out_valid), 64'(m_valid));
      check("cyc_data", 64'(data_out), m_data);
      check("cyc_cnt", 64'(sample_cnt), 64'(m_cnt));
      check("cyc_ovr", 64'(overrun), 64'(m_ovr));
      if (data_out_valid) strobes++;
    end
  end

  task automatic drive(input bit v, input logic [DATA_W-1:0] d);
    @(negedge clk);
    data_in_valid = v;
    data_in       = d;
  endtask

  task automatic after_edge;
    @(posedge clk);
    #1;
  endtask

  // Flush to IDLE, then re-enable; the next drive() lands in ACCUM.
  task automatic restart(input int l);
    @(negedge clk);
    enable = 1'b0;
    data_in_valid = 1'b0;
    @(negedge clk);
    log2_n = 4'(l);
    enable = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 64'(data_out), 64'd0);
    check("rst_valid", 64'(data_out_valid), 64'd0);
    check("rst_cnt", 64'(sample_cnt), 64'd0);
    check("rst_ovr", 64'(overrun), 64'd0);
    cmp_en = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Four-sample block: mean of 10,20,30,40.
    restart(2);
    drive(1, 10); drive(1, 20); drive(1, 30);
    after_edge;
    check("t1_cnt3", 64'(sample_cnt), 64'd3);
    drive(1, 40);
    after_edge;
    check("t1_valid", 64'(data_out_valid), 64'd1);
    check("t1_data", 64'(data_out), 64'd25);
    check("t1_cnt0", 64'(sample_cnt), 64'd0);
    drive(0, 0);
    after_edge;
    check("t1_pulse", 64'(data_out_valid), 64'd0);
    check("t1_hold", 64'(data_out), 64'd25);

    // k = 0 pass-through.
    restart(0);
    drive(1, 7);
    after_edge;
    check("t2_v7", 64'(data_out_valid), 64'd1);
    check("t2_d7", 64'(data_out), 64'd7);
    drive(1, 32'hFFFF_FFFF);
    after_edge;
    check("t2_vmax", 64'(data_out_valid), 64'd1);
    check("t2_dmax", 64'(data_out), 64'hFFFF_FFFF);
    drive(0, 0);

    // Largest block, full-scale samples back-to-back.
    restart(10);
    for (int i = 0; i < 1023; i++) drive(1, 32'hFFFF_FFFF);
    after_edge;
    check("t3_cnt1023", 64'(sample_cnt), 64'd1023);
    drive(1, 32'hFFFF_FFFF);
    after_edge;
    check("t3_valid", 64'(data_out_valid), 64'd1);
    check("t3_data", 64'(data_out), 64'hFFFF_FFFF);
    drive(1, 5);
    after_edge;
    check("t3_next_cnt", 64'(sample_cnt), 64'd1);
    check("t3_next_valid", 64'(data_out_valid), 64'd0);
    drive(0, 0);

    // Partial block discarded by enable drop; valids ignored while disabled.
    restart(3);
    for (int i = 0; i < 5; i++) drive(1, 9);
    s0 = strobes;
    @(negedge clk);
    enable = 1'b0;
    data_in_valid = 1'b1;
    data_in = 32'd9;
    repeat (3) @(negedge clk);
    data_in_valid = 1'b0;
    after_edge;
    check("t4_cnt_idle", 64'(sample_cnt), 64'd0);
    check("t4_no_strobe", 64'(strobes), 64'(s0));
    restart(3);
    for (int i = 0; i < 8; i++) drive(1, 4);
    after_edge;
    check("t4_valid", 64'(data_out_valid), 64'd1);
    check("t4_data", 64'(data_out), 64'd4);
    drive(0, 0);

    // log2_n change mid-block: overrun, old k finishes, new k next block.
    restart(2);
    drive(1, 1); drive(1, 2);
    log2_n = 4'd4;
    after_edge;
    check("t5_ovr", 64'(overrun), 64'd1);
    drive(1, 3); drive(1, 4);
    after_edge;
    check("t5_valid", 64'(data_out_valid), 64'd1);
    check("t5_data", 64'(data_out), 64'd2);
    for (int i = 0; i < 15; i++) drive(1, 32'(i));
    after_edge;
    check("t5_cnt15", 64'(sample_cnt), 64'd15);
    check("t5_nvalid", 64'(data_out_valid), 64'd0);
    drive(1, 15);
    after_edge;
    check("t5_valid16", 64'(data_out_valid), 64'd1);
    check("t5_data16", 64'(data_out), 64'd7);
    check("t5_ovr_sticky", 64'(overrun), 64'd1);
    drive(0, 0);
    @(negedge clk);
    enable = 1'b0;
    after_edge;
    check("t5_ovr_clr", 64'(overrun), 64'd0);

    // Asynchronous reset mid-block.
    restart(2);
    drive(1, 100); drive(1, 100);
    after_edge;
    check("t6_cnt2", 64'(sample_cnt), 64'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_data0", 64'(data_out), 64'd0);
    check("t6_cnt0", 64'(sample_cnt), 64'd0);
    check("t6_valid0", 64'(data_out_valid), 64'd0);
    s0 = strobes;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    data_in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("t6_no_strobe", 64'(strobes), 64'(s0));
    check("t6_cnt_after", 64'(sample_cnt), 64'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
